load_store_unit: RTL

//  Memory stage of the RV32 core. Accepts one load/store from execute per handshake,

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/load_align.sv | 38 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and request legality checks.
`default_nettype none

package lsu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

  function automatic logic lsu_f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Access size is carried in funct3[1:0] for both loads and stores.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half lane and sign- or zero-extends it.
`default_nettype none

module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32 memory stage: one load/store in flight, variable-latency memory handshake, register-file write-back.
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RF_AW = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_is_store,
  input  logic [2:0]       i_req_funct3,
  input  logic [XLEN-1:0]  i_req_addr,
  input  logic [XLEN-1:0]  i_req_wdata,
  input  logic [RF_AW-1:0] i_req_rd,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic [3:0]       o_mem_be,
  output logic [XLEN-1:0]  o_mem_wdata,
  input  logic [XLEN-1:0]  i_mem_rdata,
  input  logic             i_mem_ack,
  output logic             o_rf_we,
  output logic [RF_AW-1:0] o_rf_rd,
  output logic [XLEN-1:0]  o_rf_wd,
  output logic             o_done,
  output logic             o_err
);

  lsu_state_t       r_state;
  lsu_state_t       w_next;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [RF_AW-1:0] r_rd;
  logic [XLEN-1:0]  r_mem_addr;
  logic [3:0]       r_mem_be;
  logic [XLEN-1:0]  r_mem_wdata;
  logic             r_mem_we;
  logic [XLEN-1:0]  r_rf_wd;

  logic             w_accept;
  logic             w_bad;
  logic [3:0]       w_be;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_aligned;

  assign w_accept = i_req_valid && (r_state == IDLE);
  assign w_bad    = lsu_f3_illegal(i_req_is_store, i_req_funct3)
                 || lsu_misaligned(i_req_funct3, i_req_addr[1:0]);

  // Loads read the whole word; lane selection happens on the returned data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_req_wdata;
    if (i_req_is_store) begin
      case (i_req_funct3)
        F3_B: begin
          w_be    = 4'b0001 << i_req_addr[1:0];
          w_wdata = {4{i_req_wdata[7:0]}};
        end
        F3_H: begin
          w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = i_req_wdata;
        end
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata   (i_mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_rd        <= '0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rf_wd     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_store <= i_req_is_store;
        r_funct3   <= i_req_funct3;
        r_addr_lo  <= i_req_addr[1:0];
        r_rd       <= i_req_rd;
        if (!w_bad) begin
          r_mem_addr  <= {i_req_addr[XLEN-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
          r_mem_we    <= i_req_is_store;
        end
      end
      if ((r_state == REQ) && i_mem_ack && !r_is_store) begin
        r_rf_wd <= w_aligned;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_rf_we     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          w_next = w_bad ? ERR : REQ;
        end
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_next = r_is_store ? IDLE : WB;
          o_done = r_is_store;
        end
      end
      WB: begin
        o_rf_we = (r_rd != '0);
        o_done  = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        o_err  = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  assign o_mem_we    = r_mem_we && (r_state == REQ);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rf_rd     = r_rd;
  assign o_rf_wd     = r_rf_wd;

endmodule

`default_nettype wire
